// File: rtl/histo_readout_seq_pkg.sv
// Shared types and constants for the histogram readout sequencer.
package histo_readout_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SELECT,
        CAPTURE,
        SEND,
        CLEAR,
        DONE
    } state_t;

    localparam logic [7:0]  HEADER_DEF   = 8'hA5;
    localparam int unsigned NHIST_DEF    = 8;
    localparam int unsigned BYTES_PER_CH = NHIST_DEF * 4;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/histo_readout_seq_byte_mux.sv
// Snapshot register for one channel's histogram words plus a byte-select read port.
// Byte order: word 0 first, each word MSB byte first.
module histo_byte_mux
    import histo_readout_seq_pkg::*;
#(
    parameter int unsigned NHIST = 8,
    parameter int unsigned IW    = 5
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  load,
    input  logic [NHIST*32-1:0]   din,
    input  logic [IW-1:0]         idx,
    output logic [7:0]            byte_c
);

    localparam int unsigned OW = IW + 3;

    logic [NHIST*32-1:0] snap;
    logic [NHIST*32-1:0] src;
    logic [OW-1:0]       off;

    // Capture the presented words only on load.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            snap <= '0;
        end else if (load) begin
            snap <= din;
        end
    end

    // Read through to din while loading so the first byte is ready with the snapshot.
    always_comb begin
        src    = load ? din : snap;
        off    = {idx[IW-1:2], ~idx[1:0], 3'b000};
        byte_c = src[off +: 8];
    end

endmodule

// File: rtl/histo_readout_seq.sv
// Walks every histogram channel, snapshots its words and streams a framed byte dump.
module histo_readout_seq
    import histo_readout_seq_pkg::*;
#(
    parameter int unsigned NCHAN     = 16,
    parameter int unsigned NHIST     = 8,
    parameter int unsigned SETTLE    = 8,
    parameter int unsigned RESET_LEN = 4,
    parameter logic [7:0]  HEADER    = HEADER_DEF
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic                  clear_after,
    input  logic [NHIST*32-1:0]   histos_in,
    output logic [7:0]            hist_sel,
    output logic                  reset_hist,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned BPC  = NHIST * 4;
    localparam int unsigned CW   = cnt_w(NCHAN);
    localparam int unsigned BW   = cnt_w(BPC);
    localparam int unsigned TMAX = (SETTLE > RESET_LEN) ? SETTLE : RESET_LEN;
    localparam int unsigned TW   = cnt_w(TMAX);

    state_t          state, state_nxt;
    logic [CW-1:0]   chan, chan_nxt;
    logic [BW-1:0]   byte_cnt, byte_nxt;
    logic [TW-1:0]   tmr, tmr_nxt;
    logic            clr, clr_nxt;
    logic            load_c;
    logic [7:0]      byte_c;

    histo_byte_mux #(
        .NHIST (NHIST),
        .IW    (BW)
    ) u_byte_mux (
        .clk    (clk),
        .nrst   (nrst),
        .load   (load_c),
        .din    (histos_in),
        .idx    (byte_nxt),
        .byte_c (byte_c)
    );

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= IDLE;
            chan       <= '0;
            byte_cnt   <= '0;
            tmr        <= '0;
            clr        <= 1'b0;
            hist_sel   <= '0;
            reset_hist <= 1'b0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            chan       <= chan_nxt;
            byte_cnt   <= byte_nxt;
            tmr        <= tmr_nxt;
            clr        <= clr_nxt;
            reset_hist <= (state_nxt == CLEAR);
            tx_valid   <= (state_nxt == HDR) || (state_nxt == SEND);
            busy       <= (state_nxt != IDLE);
            done       <= (state_nxt == DONE);
            if (state_nxt == HDR) begin
                tx_data <= HEADER;
            end else if (state_nxt == SEND) begin
                tx_data <= byte_c;
            end else begin
                tx_data <= 8'h00;
            end
            if (state_nxt == IDLE) begin
                hist_sel <= '0;
            end else if (state_nxt == SELECT) begin
                hist_sel <= 8'(chan_nxt);
            end
        end
    end

    // Next-state and counter updates; a byte moves only on valid & ready.
    always_comb begin
        state_nxt = state;
        chan_nxt  = chan;
        byte_nxt  = byte_cnt;
        tmr_nxt   = tmr;
        clr_nxt   = clr;
        load_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr_nxt   = clear_after;
                    state_nxt = HDR;
                end
            end
            HDR: begin
                if (tx_ready) begin
                    chan_nxt  = '0;
                    tmr_nxt   = TW'(SETTLE - 1);
                    state_nxt = SELECT;
                end
            end
            SELECT: begin
                if (tmr == '0) begin
                    state_nxt = CAPTURE;
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            CAPTURE: begin
                load_c    = 1'b1;
                byte_nxt  = '0;
                state_nxt = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    if (byte_cnt != BW'(BPC - 1)) begin
                        byte_nxt = byte_cnt + BW'(1);
                    end else if (chan != CW'(NCHAN - 1)) begin
                        chan_nxt  = chan + CW'(1);
                        tmr_nxt   = TW'(SETTLE - 1);
                        state_nxt = SELECT;
                    end else if (clr) begin
                        tmr_nxt   = TW'(RESET_LEN - 1);
                        state_nxt = CLEAR;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            CLEAR: begin
                if (tmr == '0) begin
                    state_nxt = DONE;
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_histo_readout_seq.sv
// Self-checking bench: random histogram tables, framed-dump reference built from the byte-order rules.
module tb_histo_readout_seq;
    import histo_readout_seq_pkg::*;

    localparam int NCHAN     = 16;
    localparam int NHIST     = 8;
    localparam int SETTLE    = 8;
    localparam int RESET_LEN = 4;
    localparam int BPC       = BYTES_PER_CH;
    localparam int FRAME_LEN = 1 + NCHAN * BPC;
    localparam int BUDGET    = 20000;

    logic                 clk = 1'b0;
    logic                 nrst;
    logic                 start;
    logic                 clear_after;
    logic [NHIST*32-1:0]  histos_in;
    logic [7:0]           hist_sel;
    logic                 reset_hist;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 busy;
    logic                 done;

    histo_readout_seq dut (
        .clk         (clk),
        .nrst        (nrst),
        .start       (start),
        .clear_after (clear_after),
        .histos_in   (histos_in),
        .hist_sel    (hist_sel),
        .reset_hist  (reset_hist),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    int          n_fail  = 0;
    logic [31:0] tbl [NCHAN][NHIST];
    int          stable_cnt = 0;
    logic [7:0]  prev_sel   = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_table(input bit pattern);
        for (int ch = 0; ch < NCHAN; ch++)
            for (int k = 0; k < NHIST; k++)
                tbl[ch][k] = pattern ? (32'h0100_0000 * k + ch) : $urandom();
    endtask

    // One clock: sample outputs just after the edge, then present histos_in.
    // Table data appears only once hist_sel has been steady for more than SETTLE
    // cycles and nothing is being sent; otherwise histos_in carries noise.
    task automatic tick();
        int idx;
        @(posedge clk);
        #1;
        if (hist_sel == prev_sel) stable_cnt++;
        else stable_cnt = 1;
        prev_sel = hist_sel;
        idx = int'(hist_sel);
        for (int w = 0; w < NHIST; w++) begin
            if (!tx_valid && stable_cnt > SETTLE && idx < NCHAN)
                histos_in[32*w +: 32] = tbl[idx][w];
            else
                histos_in[32*w +: 32] = $urandom();
        end
    endtask

    // Start one dump, collect accepted bytes, then compare against the table.
    task automatic run_frame(input bit clr, input int ready_mode, input bit spam, input bit pat_chk);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        logic [7:0] prev_data = 8'h00;
        logic       prev_stall = 1'b0;
        logic       busy_at_done = 1'b0;
        bit         seen_done = 0;
        int         k = 0, done_k = 0, acc_k = 0, rh_first = 0, rh_cnt = 0;
        int         busy_low = 0, bad = 0, extra = 0, n;

        exp_q.push_back(HEADER_DEF);
        for (int ch = 0; ch < NCHAN; ch++)
            for (int w = 0; w < NHIST; w++)
                for (int b = 3; b >= 0; b--)
                    exp_q.push_back(8'(tbl[ch][w] >> (8 * b)));

        start       = 1'b1;
        clear_after = clr;
        tx_ready    = (ready_mode == 0);
        while (!seen_done && k < BUDGET) begin
            tick();
            k++;
            if (prev_stall) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_data", 32'(tx_data), 32'(prev_data));
            end
            if (reset_hist) begin
                if (rh_cnt == 0) rh_first = k;
                rh_cnt++;
            end
            if (!busy) busy_low++;
            if (done) begin
                seen_done    = 1;
                done_k       = k;
                busy_at_done = busy;
            end
            start       = (spam && !seen_done) ? ($urandom_range(0, 7) == 0) : 1'b0;
            clear_after = spam ? 1'($urandom_range(0, 1)) : 1'b0;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (k % 3 == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                acc_k = k;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
        start = 1'b0;
        check("done_seen", 32'(seen_done), 32'd1);
        check("busy_at_done", 32'(busy_at_done), 32'd1);
        check("busy_during_frame", 32'(busy_low), 32'd0);
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_falls", 32'(busy), 32'd0);
        check("hist_sel_idle", 32'(hist_sel), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_valid || busy) extra++;
        end
        check("no_second_frame", 32'(extra), 32'd0);

        check("frame_len", 32'(got_q.size()), 32'(FRAME_LEN));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i] !== exp_q[i]) bad++;
        check("frame_bytes", 32'(bad), 32'd0);
        check("reset_hist_len", 32'(rh_cnt), clr ? 32'(RESET_LEN) : 32'd0);
        check("done_after_last", 32'(done_k), 32'(acc_k + 1 + (clr ? RESET_LEN : 0)));
        if (clr) check("clear_after_last", 32'(rh_first), 32'(acc_k + 1));
        if (ready_mode == 0)
            check("dump_time", 32'(done_k),
                  32'(1 + NCHAN * (SETTLE + 1 + BPC) + (clr ? RESET_LEN : 0) + 1));
        if (pat_chk) begin
            if (got_q.size() >= 109) begin
                check("first_byte", 32'(got_q[0]), 32'h0000_00A5);
                check("ch3_w2_b0", 32'(got_q[105]), 32'h0000_0002);
                check("ch3_w2_b1", 32'(got_q[106]), 32'h0000_0000);
                check("ch3_w2_b2", 32'(got_q[107]), 32'h0000_0000);
                check("ch3_w2_b3", 32'(got_q[108]), 32'h0000_0003);
            end else begin
                check("pattern_len", 32'(got_q.size()), 32'(FRAME_LEN));
            end
        end
    endtask

    initial begin
        bit found;
        int acc5;

        nrst        = 1'b0;
        start       = 1'b0;
        clear_after = 1'b0;
        tx_ready    = 1'b0;
        histos_in   = '0;
        fill_table(1);
        tick();
        tick();
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_reset_hist", 32'(reset_hist), 32'd0);
        check("rst_hist_sel", 32'(hist_sel), 32'd0);
        nrst = 1'b1;
        tick();
        tick();

        // Counting pattern, full-rate transmitter, no clear.
        run_frame(0, 0, 0, 1);
        // Same table with a transmitter that accepts one cycle in three.
        run_frame(0, 1, 0, 1);
        // Random table with clear after the dump.
        fill_table(0);
        run_frame(1, 0, 0, 0);
        // Random back-pressure and start hammered during the dump.
        fill_table(0);
        run_frame(0, 2, 1, 0);
        // A fresh start after done begins a new frame.
        fill_table(0);
        run_frame(1, 2, 0, 0);

        // Abort mid-SEND of channel 5 with a clear-after dump in flight.
        fill_table(0);
        start       = 1'b1;
        clear_after = 1'b1;
        tx_ready    = 1'b1;
        found       = 0;
        acc5        = 0;
        for (int i = 0; i < BUDGET && !found; i++) begin
            tick();
            start       = 1'b0;
            clear_after = 1'b0;
            if (hist_sel == 8'd5 && tx_valid) begin
                if (acc5 >= 3) found = 1;
                else if (tx_ready) acc5++;
            end
            if (!found) tx_ready = 1'($urandom_range(0, 1));
        end
        check("reach_ch5", 32'(found), 32'd1);
        nrst = 1'b0;
        tick();
        check("abort_tx_valid", 32'(tx_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hist_sel", 32'(hist_sel), 32'd0);
        check("abort_reset_hist", 32'(reset_hist), 32'd0);
        nrst     = 1'b1;
        tx_ready = 1'b1;
        found    = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_valid || busy || done) found = 1;
        end
        check("abort_no_trailing", 32'(found), 32'd0);
        // Clear latch must not survive the reset.
        fill_table(0);
        run_frame(0, 2, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
